// File: rtl/mon_domain_in.sv
// Converts a message into the Montgomery domain: M_bar = M*R mod n and x_bar = R mod n,
// with R = 2^BITLEN, using one modular doubling per cycle on both values in parallel.
module mon_domain_in #(
   parameter int unsigned BITLEN = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [BITLEN-1:0] M,
   input  logic [BITLEN-1:0] n,
   output logic [BITLEN-1:0] M_bar,
   output logic [BITLEN-1:0] x_bar,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned CW = $clog2(BITLEN) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [BITLEN-1:0] n_q, n_d;
   logic [BITLEN-1:0] rm_q, rm_d;
   logic [BITLEN-1:0] rx_q, rx_d;
   logic [CW-1:0]     count_q, count_d;
   logic [BITLEN-1:0] m_bar_q, m_bar_d;
   logic [BITLEN-1:0] x_bar_q, x_bar_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              inputs_ok_c;

   // 2*r mod n for r < n; the doubled value needs one extra bit before reduction
   function automatic logic [BITLEN-1:0] mod_dbl(input logic [BITLEN-1:0] r,
                                                 input logic [BITLEN-1:0] m);
      logic [BITLEN:0] t;
      t = {r, 1'b0};
      if (t >= {1'b0, m}) t = t - {1'b0, m};
      return t[BITLEN-1:0];
   endfunction

   assign inputs_ok_c = n[0] && (n >= BITLEN'(3)) && (M < n);

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      rm_d    = rm_q;
      rx_d    = rx_q;
      count_d = count_q;
      m_bar_d = m_bar_q;
      x_bar_d = x_bar_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (inputs_ok_c) begin
                  n_d     = n;
                  rm_d    = M;
                  rx_d    = BITLEN'(1);
                  count_d = '0;
                  busy_d  = 1'b1;
                  state_d = CALC;
               end else begin
                  err_d   = 1'b1;
                  m_bar_d = '0;
                  x_bar_d = '0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end
         end
         CALC: begin
            rm_d    = mod_dbl(rm_q, n_q);
            rx_d    = mod_dbl(rx_q, n_q);
            count_d = count_q + CW'(1);
            if (count_q == CW'(BITLEN - 1)) begin
               m_bar_d = rm_d;
               x_bar_d = rx_d;
               err_d   = 1'b0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         n_q     <= '0;
         rm_q    <= '0;
         rx_q    <= '0;
         count_q <= '0;
         m_bar_q <= '0;
         x_bar_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         rm_q    <= rm_d;
         rx_q    <= rx_d;
         count_q <= count_d;
         m_bar_q <= m_bar_d;
         x_bar_q <= x_bar_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign M_bar = m_bar_q;
   assign x_bar = x_bar_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign err   = err_q;

endmodule

// File: tb/tb_mon_domain_in.sv
// Directed bench for mon_domain_in at BITLEN=8 (R=256) with hand-computed Montgomery values.
module tb_mon_domain_in;

   localparam int unsigned BITLEN = 8;

   logic              clk;
   logic              rst;
   logic              start;
   logic [BITLEN-1:0] m_i;
   logic [BITLEN-1:0] n_i;
   logic [BITLEN-1:0] m_bar;
   logic [BITLEN-1:0] x_bar;
   logic              busy;
   logic              done;
   logic              err;

   int errors = 0;
   int checks = 0;

   mon_domain_in #(.BITLEN(BITLEN)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .M     (m_i),
      .n     (n_i),
      .M_bar (m_bar),
      .x_bar (x_bar),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-cycle start pulse; edge 1 is the edge that samples start. Reports the edge
   // of the first done, busy-high samples and total done-high samples (bounded).
   task automatic do_req(input logic [7:0] nv, input logic [7:0] mv,
                         output int lat, output int bcyc, output int dwidth);
      lat = -1; bcyc = 0; dwidth = 0;
      n_i = nv; m_i = mv; start = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (busy) bcyc++;
         if (done) begin
            dwidth++;
            if (lat < 0) lat = e;
         end else if (lat >= 0) begin
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; m_i = '0; n_i = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (m_bar !== 8'd0) begin errors++; $display("FAIL reset_m_bar got=%0d exp=0", m_bar); end
      checks++; if (x_bar !== 8'd0) begin errors++; $display("FAIL reset_x_bar got=%0d exp=0", x_bar); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int lat, bcyc, dw;
      do_req(8'd13, 8'd5, lat, bcyc, dw);
      checks++; if (lat !== 9) begin errors++; $display("FAIL basic_latency got=%0d exp=9", lat); end
      checks++; if (bcyc !== 8) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=8", bcyc); end
      checks++; if (dw !== 1) begin errors++; $display("FAIL basic_done_width got=%0d exp=1", dw); end
      checks++; if (x_bar !== 8'd9) begin errors++; $display("FAIL basic_x_bar got=%0d exp=9", x_bar); end
      checks++; if (m_bar !== 8'd6) begin errors++; $display("FAIL basic_m_bar got=%0d exp=6", m_bar); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err got=%b exp=0", err); end
   endtask

   task automatic test_corner();
      int lat, bcyc, dw;
      do_req(8'd251, 8'd250, lat, bcyc, dw);
      checks++; if (lat !== 9) begin errors++; $display("FAIL c251_latency got=%0d exp=9", lat); end
      checks++; if (x_bar !== 8'd5) begin errors++; $display("FAIL c251_x_bar got=%0d exp=5", x_bar); end
      checks++; if (m_bar !== 8'd246) begin errors++; $display("FAIL c251_m_bar got=%0d exp=246", m_bar); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL c251_err got=%b exp=0", err); end
      do_req(8'd255, 8'd0, lat, bcyc, dw);
      checks++; if (dw !== 1) begin errors++; $display("FAIL c255_done_width got=%0d exp=1", dw); end
      checks++; if (x_bar !== 8'd1) begin errors++; $display("FAIL c255_x_bar got=%0d exp=1", x_bar); end
      checks++; if (m_bar !== 8'd0) begin errors++; $display("FAIL c255_m_bar got=%0d exp=0", m_bar); end
   endtask

   task automatic test_invalid();
      int lat, bcyc, dw;
      logic [7:0] nv [3];
      logic [7:0] mv [3];
      nv[0] = 8'd12; mv[0] = 8'd5;
      nv[1] = 8'd13; mv[1] = 8'd13;
      nv[2] = 8'd1;  mv[2] = 8'd0;
      for (int k = 0; k < 3; k++) begin
         // leave a known non-zero result behind so the clearing is observable
         do_req(8'd13, 8'd5, lat, bcyc, dw);
         do_req(nv[k], mv[k], lat, bcyc, dw);
         checks++; if (lat !== 1) begin errors++; $display("FAIL inv%0d_latency got=%0d exp=1", k, lat); end
         checks++; if (dw !== 1) begin errors++; $display("FAIL inv%0d_done_width got=%0d exp=1", k, dw); end
         checks++; if (bcyc !== 0) begin errors++; $display("FAIL inv%0d_busy got=%0d exp=0", k, bcyc); end
         checks++; if (err !== 1'b1) begin errors++; $display("FAIL inv%0d_err got=%b exp=1", k, err); end
         checks++; if (m_bar !== 8'd0) begin errors++; $display("FAIL inv%0d_m_bar got=%0d exp=0", k, m_bar); end
         checks++; if (x_bar !== 8'd0) begin errors++; $display("FAIL inv%0d_x_bar got=%0d exp=0", k, x_bar); end
      end
   endtask

   task automatic test_hold_start();
      int ndone, first_e, second_e;
      logic [7:0] xb [2];
      logic [7:0] mb [2];
      ndone = 0; first_e = -1; second_e = -1;
      xb[0] = '0; xb[1] = '0; mb[0] = '0; mb[1] = '0;
      n_i = 8'd13; m_i = 8'd5; start = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk); #1;
         if (done) begin
            if (ndone == 0) first_e = e;
            if (ndone == 1) second_e = e;
            if (ndone < 2) begin xb[ndone] = x_bar; mb[ndone] = m_bar; end
            ndone++;
         end
      end
      start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      checks++; if (ndone !== 2) begin errors++; $display("FAIL hold_done_count got=%0d exp=2", ndone); end
      checks++; if (first_e !== 9) begin errors++; $display("FAIL hold_first_edge got=%0d exp=9", first_e); end
      checks++; if (second_e !== 19) begin errors++; $display("FAIL hold_second_edge got=%0d exp=19", second_e); end
      checks++; if (xb[0] !== 8'd9 || mb[0] !== 8'd6) begin errors++; $display("FAIL hold_first_result got=%0d/%0d exp=9/6", xb[0], mb[0]); end
      checks++; if (xb[1] !== 8'd9 || mb[1] !== 8'd6) begin errors++; $display("FAIL hold_second_result got=%0d/%0d exp=9/6", xb[1], mb[1]); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL hold_err got=%b exp=0", err); end
   endtask

   task automatic test_input_change();
      int lat, dw;
      logic stable_ok;
      lat = -1; dw = 0; stable_ok = 1'b1;
      do_req(8'd251, 8'd250, lat, dw, dw);
      lat = -1; dw = 0;
      n_i = 8'd13; m_i = 8'd5; start = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk); #1;
         if (e == 4) begin n_i = 8'd251; m_i = 8'd250; end
         if (lat < 0 && !done && (x_bar !== 8'd5 || m_bar !== 8'd246)) stable_ok = 1'b0;
         if (done) begin dw++; if (lat < 0) lat = e; end
         else if (lat >= 0) break;
         // keep start high only briefly so the bench does not re-trigger
         if (e == 2) start = 1'b0;
      end
      checks++; if (stable_ok !== 1'b1) begin errors++; $display("FAIL chg_hold_during_calc got=%b exp=1", stable_ok); end
      checks++; if (lat !== 9) begin errors++; $display("FAIL chg_latency got=%0d exp=9", lat); end
      checks++; if (dw !== 1) begin errors++; $display("FAIL chg_done_width got=%0d exp=1", dw); end
      checks++; if (x_bar !== 8'd9) begin errors++; $display("FAIL chg_x_bar got=%0d exp=9", x_bar); end
      checks++; if (m_bar !== 8'd6) begin errors++; $display("FAIL chg_m_bar got=%0d exp=6", m_bar); end
   endtask

   task automatic test_reset_mid();
      int ndone, lat, bcyc, dw;
      ndone = 0;
      n_i = 8'd13; m_i = 8'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (m_bar !== 8'd0) begin errors++; $display("FAIL rmid_m_bar got=%0d exp=0", m_bar); end
      checks++; if (x_bar !== 8'd0) begin errors++; $display("FAIL rmid_x_bar got=%0d exp=0", x_bar); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rmid_err got=%b exp=0", err); end
      rst = 1'b0;
      repeat (15) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      checks++; if (ndone !== 0) begin errors++; $display("FAIL rmid_no_done got=%0d exp=0", ndone); end
      do_req(8'd251, 8'd250, lat, bcyc, dw);
      checks++; if (lat !== 9) begin errors++; $display("FAIL rmid_new_latency got=%0d exp=9", lat); end
      checks++; if (x_bar !== 8'd5) begin errors++; $display("FAIL rmid_new_x_bar got=%0d exp=5", x_bar); end
      checks++; if (m_bar !== 8'd246) begin errors++; $display("FAIL rmid_new_m_bar got=%0d exp=246", m_bar); end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; m_i = '0; n_i = '0;
      test_reset();
      test_basic();
      test_corner();
      test_invalid();
      test_hold_start();
      test_input_change();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mon_domain_in.md
MON_DOMAIN_IN -- requirements
Module: mon_domain_in

Interface
REQ-001 Parameter: BITLEN, default 1024, operand width in bits; the Montgomery radix is R = 2^BITLEN.
REQ-002 Port: clk  input  1  rising-edge clock, the only clock in the block.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port: start  input  1  request pulse, sampled only in IDLE.
REQ-005 Port: M  input  BITLEN  plaintext or ciphertext message; must be less than n.
REQ-006 Port: n  input  BITLEN  modulus; must be odd and at least 3.
REQ-007 Port: M_bar  output  BITLEN  M*R mod n, registered; feeds mon_exp M_bar.
REQ-008 Port: x_bar  output  BITLEN  R mod n, registered; feeds mon_exp x_bar.
REQ-009 Port: busy  output  1  high from the cycle after start is accepted until done.
REQ-010 Port: done  output  1  single-cycle pulse; results or err are valid when it is high.
REQ-011 Port: err  output  1  registered; high with done when the inputs are invalid.

Function
REQ-012 States: IDLE, CALC, DONE; encoded in 2 bits.
REQ-013 IDLE with start=1 and valid inputs: capture n; load rm <= M and rx <= 1; clear count; go to CALC; busy <= 1.
REQ-014 IDLE with start=1 and invalid inputs (n[0]=0, n<3, or M>=n): go to DONE.
  - err <= 1; M_bar <= 0; x_bar <= 0.
  - No CALC cycles are spent.
REQ-015 CALC performs one modular-doubling step per cycle on both rm and rx at once:
  - t = 2*r, computed at BITLEN+1 bits.
  - r <= (t >= n) ? t - n : t.
REQ-016 rm and rx stay below n after every step; all intermediate values fit in BITLEN+1 bits and no bit is truncated.
REQ-017 CALC runs exactly BITLEN steps; count is ceil(log2(BITLEN))+1 bits wide and increments once per step.
REQ-018 On the step where count == BITLEN-1:
  - M_bar <= rm result; x_bar <= rx result; err <= 0.
  - done <= 1; busy <= 0; go to DONE.
REQ-019 Latency for a valid request: done is high in the cycle that begins BITLEN+1 rising edges after the edge that sampled start=1.
REQ-020 Latency for an invalid request: done is high in the cycle that begins 1 rising edge after the edge that sampled start=1.
REQ-021 DONE: done <= 0 on the next edge, then go to IDLE. done is never high for more than one cycle.
REQ-022 start is ignored in CALC and DONE, including start held high continuously. A start that is high in the IDLE cycle following DONE is accepted.
REQ-023 M_bar, x_bar and err hold their values from the last completed request until the next completion or reset; they never change during CALC.
REQ-024 The inputs M and n are sampled only on the accepting edge; changes to them during CALC have no effect.

Reset
REQ-025 rst=1 on any rising edge forces state to IDLE and sets M_bar=0, x_bar=0, busy=0, done=0, err=0, count=0. This includes reset in the middle of CALC.
REQ-026 rst takes priority over start on the same edge; no done pulse is produced for a request that reset aborted.
REQ-027 There is no dependence on initial blocks; behaviour before the first reset is undefined.

Verification (BITLEN=8, R=256)
REQ-028 n=13, M=5, start for 1 cycle -> done pulse after 9 edges; x_bar=9, M_bar=6, err=0; busy high for 8 cycles.
REQ-029 n=251, M=250 -> x_bar=5, M_bar=246, err=0; then n=255, M=0 -> x_bar=1, M_bar=0.
REQ-030 Invalid inputs, each checked separately:
  - n=12, M=5 -> done after 1 edge; err=1, M_bar=0, x_bar=0.
  - n=13, M=13 -> done after 1 edge; err=1, M_bar=0, x_bar=0.
REQ-031 start held high for 20 cycles with n=13, M=5 -> done pulses at edge 9 and again at edge 19; both give x_bar=9, M_bar=6; no other done pulses.
REQ-032 Reset mid-operation: n=13, M=5, rst=1 at edge 4 -> all outputs 0, no done pulse. A new request n=251, M=250 issued afterwards completes with x_bar=5, M_bar=246.
REQ-033 Input change during CALC: change M and n in the middle of CALC -> results match the values captured at start. Done pulse width is exactly 1 cycle in every scenario.
